// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC jump controller: FSM states, condition codes,
// ALU flag layout and the registered PC drive bundle.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_WAIT = 3'd0,
    ST_IDLE       = 3'd1,
    ST_LOAD_HI    = 3'd2,
    ST_JUMP       = 3'd3,
    ST_WAIT_REL   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_C      = 3'd3,
    COND_NC     = 3'd4,
    COND_N      = 3'd5,
    COND_V      = 3'd6,
    COND_NEVER  = 3'd7
  } cond_t;

  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } flags_t;

  typedef struct packed {
    logic       pchitmp_n;
    logic       long_n;
    logic       local_n;
    logic [7:0] d;
  } pc_drv_t;

  localparam logic KIND_LOCAL = 1'b0;
  localparam logic KIND_LONG  = 1'b1;

  localparam pc_drv_t PC_DRV_IDLE = '{
    pchitmp_n: 1'b1,
    long_n:    1'b1,
    local_n:   1'b1,
    d:         8'h00
  };

  function automatic pc_drv_t drv_hitmp(
    input logic [7:0] d
  );
    pc_drv_t r;
    r = PC_DRV_IDLE;
    r.pchitmp_n = 1'b0;
    r.d = d;
    return r;
  endfunction

  function automatic pc_drv_t drv_long(
    input logic [7:0] d
  );
    pc_drv_t r;
    r = PC_DRV_IDLE;
    r.long_n = 1'b0;
    r.d = d;
    return r;
  endfunction

  function automatic pc_drv_t drv_local(
    input logic [7:0] d
  );
    pc_drv_t r;
    r = PC_DRV_IDLE;
    r.local_n = 1'b0;
    r.d = d;
    return r;
  endfunction

endpackage

// File: rtl/pc_jump_ctrl_if.sv
// Decode-side jump request handshake and PC-side strobe/data bus.
interface jump_req_if;
  import pc_ctrl_pkg::*;

  logic        req;
  logic        kind;
  cond_t       cond;
  logic [3:0]  flags;
  logic [15:0] addr;
  logic        ready;
  logic        ack;
  logic        taken;

  modport master (
    output req,
    output kind,
    output cond,
    output flags,
    output addr,
    input  ready,
    input  ack,
    input  taken
  );

  modport slave (
    input  req,
    input  kind,
    input  cond,
    input  flags,
    input  addr,
    output ready,
    output ack,
    output taken
  );

endinterface

interface pc_strobe_if;

  logic       _pchitmp_in;
  logic       _long_jump;
  logic       _local_jump;
  logic [7:0] D;

  modport master (
    output _pchitmp_in,
    output _long_jump,
    output _local_jump,
    output D
  );

  modport slave (
    input _pchitmp_in,
    input _long_jump,
    input _local_jump,
    input D
  );

endinterface

// File: rtl/pc_jump_ctrl_cond_eval.sv
// Combinational branch condition evaluation against {N,V,C,Z}.
module cond_eval
  import pc_ctrl_pkg::*;
(
  input  cond_t      cond_i,
  input  logic [3:0] flags_i,
  output logic       true_o
);

  flags_t f;

  assign f = flags_t'(flags_i);

  always_comb begin
    true_o = 1'b0;
    unique case (cond_i)
      COND_ALWAYS: true_o = 1'b1;
      COND_Z:      true_o = f.z;
      COND_NZ:     true_o = ~f.z;
      COND_C:      true_o = f.c;
      COND_NC:     true_o = ~f.c;
      COND_N:      true_o = f.n;
      COND_V:      true_o = f.v;
      COND_NEVER:  true_o = 1'b0;
      default:     true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_jump_ctrl.sv
// Sequences PC load strobes and D bus for local/long conditional jumps.
module pc_jump_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned RESET_HOLD = 2
) (
  input logic        clk,
  input logic        _MR,
  jump_req_if.slave  rq,
  pc_strobe_if.master pc
);

  localparam int unsigned CW =
    (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(RESET_HOLD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lo_q, lo_d;
  pc_drv_t       drv_q, drv_d;
  logic          ready_q, ready_d;
  logic          ack_q, ack_d;
  logic          taken_q, taken_d;
  logic          hit;

  cond_eval u_cond (
    .cond_i  (rq.cond),
    .flags_i (rq.flags),
    .true_o  (hit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    drv_d   = PC_DRV_IDLE;
    ready_d = 1'b0;
    ack_d   = 1'b0;
    taken_d = 1'b0;
    unique case (state_q)
      ST_RESET_WAIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        ready_d = 1'b1;
        if (rq.req) begin
          ready_d = 1'b0;
          lo_d    = rq.addr[7:0];
          if (!hit) begin
            state_d = ST_WAIT_REL;
            ack_d   = 1'b1;
          end else if (rq.kind == KIND_LOCAL) begin
            state_d = ST_JUMP;
            drv_d   = drv_local(rq.addr[7:0]);
          end else begin
            state_d = ST_LOAD_HI;
            drv_d   = drv_hitmp(rq.addr[15:8]);
          end
        end
      end
      ST_LOAD_HI: begin
        state_d = ST_JUMP;
        drv_d   = drv_long(lo_q);
      end
      ST_JUMP: begin
        state_d = ST_WAIT_REL;
        ack_d   = 1'b1;
        taken_d = 1'b1;
      end
      ST_WAIT_REL: begin
        // a held request must not re-trigger
        if (!rq.req) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RESET_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      state_q <= ST_RESET_WAIT;
      cnt_q   <= '0;
      lo_q    <= 8'h00;
      drv_q   <= PC_DRV_IDLE;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      drv_q   <= drv_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      taken_q <= taken_d;
    end
  end

  assign pc._pchitmp_in = drv_q.pchitmp_n;
  assign pc._long_jump  = drv_q.long_n;
  assign pc._local_jump = drv_q.local_n;
  assign pc.D           = drv_q.d;

  assign rq.ready = ready_q;
  assign rq.ack   = ack_q;
  assign rq.taken = taken_q;

  a_one_strobe: assert property (
    @(posedge clk) disable iff (!_MR)
    $countones({~drv_q.pchitmp_n,
                ~drv_q.long_n,
                ~drv_q.local_n}) <= 1
  );

  a_d_quiet: assert property (
    @(posedge clk) disable iff (!_MR)
    (drv_q.pchitmp_n && drv_q.long_n && drv_q.local_n)
      |-> (drv_q.d == 8'h00)
  );

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Directed bench: pc_jump_ctrl driving a small behavioural PC.
module tb_pc_jump_ctrl;
  import pc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic mr_n;

  always #5 clk = ~clk;

  jump_req_if  rq();
  pc_strobe_if ps();

  pc_jump_ctrl #(.RESET_HOLD(2)) dut (
    .clk (clk),
    ._MR (mr_n),
    .rq  (rq),
    .pc  (ps)
  );

  logic [15:0] pc_q;
  logic [7:0]  hitmp_q;
  logic        pc_set;
  logic [15:0] pc_val;

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      pc_q    <= 16'h0000;
      hitmp_q <= 8'h00;
    end else begin
      if (!ps._pchitmp_in) hitmp_q <= ps.D;
      if (pc_set)
        pc_q <= pc_val;
      else if (!ps._long_jump)
        pc_q <= {hitmp_q, ps.D};
      else if (!ps._local_jump)
        pc_q <= {pc_q[15:8], ps.D};
      else
        pc_q <= pc_q + 16'd1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] strb();
    return {ps._pchitmp_in, ps._long_jump,
            ps._local_jump, ps.D};
  endfunction

  function automatic logic [10:0] drv(
    input logic p, input logic l,
    input logic c, input logic [7:0] d
  );
    return {p, l, c, d};
  endfunction

  function automatic logic [2:0] stat();
    return {rq.ready, rq.ack, rq.taken};
  endfunction

  // f = {N,V,C,Z}
  function automatic logic cond_model(
    input int c, input logic [3:0] f
  );
    case (c)
      0: return 1'b1;
      1: return f[0];
      2: return !f[0];
      3: return f[1];
      4: return !f[1];
      5: return f[3];
      6: return f[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_req(
    input logic r, input logic k, input int c,
    input logic [3:0] f, input logic [15:0] a
  );
    rq.req   = r;
    rq.kind  = k;
    rq.cond  = cond_t'(c[2:0]);
    rq.flags = f;
    rq.addr  = a;
  endtask

  initial begin
    int bad;
    int n;
    logic got_ack;
    logic tk;
    logic exp_t;
    mr_n   = 1'b1;
    pc_set = 1'b0;
    pc_val = 16'h0000;
    set_req(0, KIND_LOCAL, 0, 4'h0, 16'h0000);
    #2 mr_n = 1'b0;
    #10;
    chk("rst_strobes", 32'(strb()), 32'(drv(1, 1, 1, 8'h00)));
    chk("rst_status", 32'(stat()), 32'(3'b000));
    @(posedge clk);
    #1 mr_n = 1'b1;
    tick();
    chk("rst_hold1", 32'(rq.ready), 32'(1'b0));
    tick();
    chk("rst_hold2", 32'(rq.ready), 32'(1'b1));
    chk("rst_pc", 32'(pc_q), 32'h0002);

    set_req(1, KIND_LONG, 0, 4'h0, 16'h12AB);
    pc_set = 1'b1;
    pc_val = 16'h0005;
    tick();
    pc_set = 1'b0;
    chk("long_e0_pc", 32'(pc_q), 32'h0005);
    chk("long_e0_strb", 32'(strb()), 32'(drv(0, 1, 1, 8'h12)));
    chk("long_e0_stat", 32'(stat()), 32'(3'b000));
    rq.addr  = 16'h0000;
    rq.flags = 4'hF;
    rq.kind  = KIND_LOCAL;
    rq.cond  = COND_NEVER;
    tick();
    chk("long_e1_strb", 32'(strb()), 32'(drv(1, 0, 1, 8'hAB)));
    chk("long_e1_hitmp", 32'(hitmp_q), 32'h12);
    tick();
    chk("long_e2_strb", 32'(strb()), 32'(drv(1, 1, 1, 8'h00)));
    chk("long_e2_stat", 32'(stat()), 32'(3'b011));
    chk("long_pc", 32'(pc_q), 32'h12AB);
    rq.req = 1'b0;
    tick();
    chk("long_e3_stat", 32'(stat()), 32'(3'b100));
    chk("long_e3_pc", 32'(pc_q), 32'h12AC);

    set_req(1, KIND_LOCAL, 1, 4'b0001, 16'hFF40);
    pc_set = 1'b1;
    pc_val = 16'h0310;
    tick();
    pc_set = 1'b0;
    chk("loc_e0_strb", 32'(strb()), 32'(drv(1, 1, 0, 8'h40)));
    tick();
    chk("loc_e1_strb", 32'(strb()), 32'(drv(1, 1, 1, 8'h00)));
    chk("loc_e1_stat", 32'(stat()), 32'(3'b011));
    chk("loc_pc", 32'(pc_q), 32'h0340);
    rq.req = 1'b0;
    tick();
    chk("loc_e2_stat", 32'(stat()), 32'(3'b100));

    set_req(1, KIND_LONG, 2, 4'b0001, 16'h5555);
    pc_set = 1'b1;
    pc_val = 16'h0100;
    tick();
    pc_set = 1'b0;
    chk("nt_e0_stat", 32'(stat()), 32'(3'b010));
    chk("nt_e0_strb", 32'(strb()), 32'(drv(1, 1, 1, 8'h00)));
    chk("nt_e0_pc", 32'(pc_q), 32'h0100);
    rq.req = 1'b0;
    tick();
    chk("nt_e1_stat", 32'(stat()), 32'(3'b100));
    chk("nt_e1_pc", 32'(pc_q), 32'h0101);

    set_req(1, KIND_LOCAL, 0, 4'h0, 16'h0077);
    pc_set = 1'b1;
    pc_val = 16'h0500;
    tick();
    pc_set = 1'b0;
    chk("hold_e0_strb", 32'(strb()), 32'(drv(1, 1, 0, 8'h77)));
    tick();
    chk("hold_e1_stat", 32'(stat()), 32'(3'b011));
    chk("hold_e1_pc", 32'(pc_q), 32'h0577);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rq.ack || rq.ready ||
          strb() != drv(1, 1, 1, 8'h00))
        bad++;
    end
    chk("hold_quiet", 32'(bad), 32'd0);
    chk("hold_pc", 32'(pc_q), 32'h057C);
    rq.req = 1'b0;
    tick();
    chk("hold_release", 32'(rq.ready), 32'(1'b1));

    set_req(1, KIND_LONG, 0, 4'h0, 16'hBEEF);
    tick();
    chk("mr_pre_strb", 32'(strb()), 32'(drv(0, 1, 1, 8'hBE)));
    #2 mr_n = 1'b0;
    #1;
    chk("mr_strb", 32'(strb()), 32'(drv(1, 1, 1, 8'h00)));
    chk("mr_stat", 32'(stat()), 32'(3'b000));
    chk("mr_pc", 32'(pc_q), 32'h0000);
    rq.req = 1'b0;
    @(posedge clk);
    #1 mr_n = 1'b1;
    tick();
    chk("mr_hold1", 32'(rq.ready), 32'(1'b0));
    tick();
    chk("mr_hold2", 32'(rq.ready), 32'(1'b1));
    chk("mr_pc_run", 32'(pc_q), 32'h0002);

    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        exp_t = cond_model(c, 4'(f));
        set_req(1, KIND_LOCAL, c, 4'(f),
                {8'h00, 8'(c * 16 + f)});
        n = 0;
        got_ack = 1'b0;
        tk = 1'b0;
        while (!got_ack && n < 4) begin
          tick();
          n++;
          if (rq.ack) begin
            got_ack = 1'b1;
            tk = rq.taken;
          end
        end
        chk($sformatf("sweep_taken c%0d f%0h", c, f),
            32'(tk), 32'(exp_t));
        chk($sformatf("sweep_lat c%0d f%0h", c, f),
            32'(n), exp_t ? 32'd2 : 32'd1);
        rq.req = 1'b0;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
